// File: rtl/aes_dec_axi_sequencer.sv
// AXI4-Lite master sequencing one AES-128 decrypt per request on the wrapper slave.
// Optional key cache: define AES_SEQ_KEY_CACHE_EN to skip key writes for a repeated key.
module aes_dec_axi_sequencer #(
    parameter int DEC_WAIT_CYCLES = 16,
    parameter int ADDR_W          = 6
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [127:0]      req_key,
    input  logic [127:0]      req_cipher,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [127:0]      rsp_plain,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [2:0]        M_AXI_AWPROT,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WB, S_WAIT, S_RAR, S_RR, S_RESP
    } state_t;

    state_t            state_q;
    logic [127:0]      key_q, cipher_q, plain_q;
    logic [2:0]        widx_q;
    logic [1:0]        ridx_q;
    logic [7:0]        wait_q;
    logic              err_q, req_ready_q, rsp_valid_q;
    logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        widx_d, start_d;
    logic [1:0]        ridx_d;
    logic              wr_done_d;

    // Word index 0..3 selects key words, 4..7 cipher words
    function automatic logic [ADDR_W-1:0] wr_addr(input logic [2:0] i);
        return ADDR_W'({~i[2], i[1:0], 2'b00});
    endfunction

    function automatic logic [31:0] wr_word(input logic [127:0] k,
                                            input logic [127:0] c,
                                            input logic [2:0]   i);
        logic [127:0] v;
        v = i[2] ? c : k;
        return v[{~i[1:0], 5'd0} +: 32];
    endfunction

    function automatic logic [ADDR_W-1:0] rd_addr(input logic [1:0] i);
        return ADDR_W'({2'b10, i, 2'b00});
    endfunction

    assign widx_d    = widx_q + 3'd1;
    assign ridx_d    = ridx_q + 2'd1;
    assign wr_done_d = (!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY);

`ifdef AES_SEQ_KEY_CACHE_EN
    logic [127:0] ckey_q;
    logic         cvld_q;
    assign start_d = (cvld_q && (req_key == ckey_q)) ? 3'd4 : 3'd0;
`else
    assign start_d = 3'd0;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            cipher_q    <= '0;
            plain_q     <= '0;
            widx_q      <= '0;
            ridx_q      <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
`ifdef AES_SEQ_KEY_CACHE_EN
            ckey_q      <= '0;
            cvld_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: if (req_valid) begin
                    key_q       <= req_key;
                    cipher_q    <= req_cipher;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b0;
                    widx_q      <= start_d;
                    ridx_q      <= 2'd0;
                    awaddr_q    <= wr_addr(start_d);
                    wdata_q     <= wr_word(req_key, req_cipher, start_d);
                    awvalid_q   <= 1'b1;
                    wvalid_q    <= 1'b1;
                    state_q     <= S_WR;
                end
                S_WR: begin
                    if (M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (wr_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WB;
                    end
                end
                S_WB: if (M_AXI_BVALID) begin
                    bready_q <= 1'b0;
                    if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
`ifdef AES_SEQ_KEY_CACHE_EN
                    if (M_AXI_BRESP != 2'b00) begin
                        cvld_q <= 1'b0;
                    end else if (widx_q == 3'd3 && !err_q) begin
                        cvld_q <= 1'b1;
                        ckey_q <= key_q;
                    end
`endif
                    if (widx_q == 3'd7) begin
                        if (DEC_WAIT_CYCLES == 0) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= rd_addr(2'd0);
                            state_q   <= S_RAR;
                        end else begin
                            wait_q  <= 8'(DEC_WAIT_CYCLES);
                            state_q <= S_WAIT;
                        end
                    end else begin
                        widx_q    <= widx_d;
                        awaddr_q  <= wr_addr(widx_d);
                        wdata_q   <= wr_word(key_q, cipher_q, widx_d);
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WR;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 8'd1) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= rd_addr(ridx_q);
                        state_q   <= S_RAR;
                    end else begin
                        wait_q <= wait_q - 8'd1;
                    end
                end
                S_RAR: if (M_AXI_ARREADY) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= S_RR;
                end
                S_RR: if (M_AXI_RVALID) begin
                    rready_q <= 1'b0;
                    plain_q[{~ridx_q, 5'd0} +: 32] <= M_AXI_RDATA;
                    if (M_AXI_RRESP != 2'b00) err_q <= 1'b1;
`ifdef AES_SEQ_KEY_CACHE_EN
                    if (M_AXI_RRESP != 2'b00) cvld_q <= 1'b0;
`endif
                    if (ridx_q == 2'd3) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        ridx_q    <= ridx_d;
                        araddr_q  <= rd_addr(ridx_d);
                        arvalid_q <= 1'b1;
                        state_q   <= S_RAR;
                    end
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_plain     = plain_q;
    assign rsp_err       = err_q;
    assign busy          = (state_q != S_IDLE);
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_aes_dec_axi_sequencer.sv
// Bench for aes_dec_axi_sequencer: AXI-Lite slave BFM with random delays and
// error injection, checked against a job-level transaction model.
module tb_aes_dec_axi_sequencer;
    localparam int WAITC = 16;
    localparam int AW    = 6;
`ifdef AES_SEQ_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [127:0]  req_key = '0;
    logic [127:0]  req_cipher = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [127:0]  rsp_plain;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] M_AXI_AWADDR;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_AWVALID;
    logic          M_AXI_AWREADY = 1'b0;
    logic [31:0]   M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY = 1'b0;
    logic [1:0]    M_AXI_BRESP = 2'b00;
    logic          M_AXI_BVALID = 1'b0;
    logic          M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY = 1'b0;
    logic [31:0]   M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = 2'b00;
    logic          M_AXI_RVALID = 1'b0;
    logic          M_AXI_RREADY;

    aes_dec_axi_sequencer #(.DEC_WAIT_CYCLES(WAITC), .ADDR_W(AW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_cipher(req_cipher),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_plain(rsp_plain), .rsp_err(rsp_err), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int dly(input int lo, input int hi);
        if (hi <= lo) return lo;
        return int'($urandom_range(hi, lo));
    endfunction

    // slave BFM state
    int aw_min = 0, aw_max = 1, w_min = 0, w_max = 1, b_min = 0, b_max = 1;
    int ar_min = 0, ar_max = 1, r_min = 0, r_max = 1;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire;
    bit aw_got, w_got, b_pend, r_pend;
    bit aw_hold, w_hold, ar_hold;
    logic [AW-1:0] aw_a, aw_hold_a, ar_hold_a;
    logic [31:0]   w_d, w_hold_d, r_data;
    logic [1:0]    b_resp, r_resp;
    logic [7:0]    err_addr = 8'hFF;
    logic [31:0]   rmem [4];
    logic [7:0]    wlog_a [$];
    logic [31:0]   wlog_d [$];
    logic [7:0]    rlog_a [$];
    int  ncyc = 0, last_b_cyc = 0, ar_gap = 0;
    bit  ar_seen;

    always @(negedge ACLK) begin
        ncyc++;
        if (!ARESETN) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
            M_AXI_BVALID = 0; M_AXI_BRESP = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
            M_AXI_RDATA = 0; M_AXI_RRESP = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_hold = 0; w_hold = 0; ar_hold = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            if (aw_hold) chk("aw_stable", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, aw_hold_a});
            if (w_hold)  chk("w_stable", {M_AXI_WVALID, M_AXI_WDATA}, {1'b1, w_hold_d});
            if (ar_hold) chk("ar_stable", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, ar_hold_a});
            // read data channel
            if (r_fire) begin
                M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; r_fire = 0;
            end else if (r_pend) begin
                if (r_cnt == 0) begin
                    M_AXI_RVALID = 1; M_AXI_RDATA = r_data; M_AXI_RRESP = r_resp; r_pend = 0;
                end else r_cnt--;
            end
            if (M_AXI_RVALID && !r_fire && M_AXI_RREADY) r_fire = 1;
            // write response channel
            if (b_fire) begin
                M_AXI_BVALID = 0; M_AXI_BRESP = 0; b_fire = 0;
            end else if (b_pend) begin
                if (b_cnt == 0) begin
                    M_AXI_BVALID = 1; M_AXI_BRESP = b_resp; b_pend = 0;
                end else b_cnt--;
            end
            if (M_AXI_BVALID && !b_fire && M_AXI_BREADY) begin
                b_fire = 1; last_b_cyc = ncyc;
            end
            // write address / data channels
            if (aw_fire) begin
                M_AXI_AWREADY = 0; aw_fire = 0; aw_cnt = dly(aw_min, aw_max);
            end else if (M_AXI_AWVALID) begin
                if (aw_cnt == 0) begin
                    M_AXI_AWREADY = 1; aw_fire = 1; aw_a = M_AXI_AWADDR; aw_got = 1;
                    chk("awprot", M_AXI_AWPROT, 3'b000);
                end else aw_cnt--;
            end
            if (w_fire) begin
                M_AXI_WREADY = 0; w_fire = 0; w_cnt = dly(w_min, w_max);
            end else if (M_AXI_WVALID) begin
                if (w_cnt == 0) begin
                    M_AXI_WREADY = 1; w_fire = 1; w_d = M_AXI_WDATA; w_got = 1;
                    chk("wstrb", M_AXI_WSTRB, 4'hF);
                end else w_cnt--;
            end
            if (aw_got && w_got) begin
                wlog_a.push_back(8'(aw_a));
                wlog_d.push_back(w_d);
                aw_got = 0; w_got = 0; b_pend = 1;
                b_cnt = dly(b_min, b_max);
                b_resp = (8'(aw_a) == err_addr) ? 2'b10 : 2'b00;
            end
            // read address channel
            if (M_AXI_ARVALID && !ar_seen) begin
                ar_seen = 1; ar_gap = ncyc - last_b_cyc;
            end
            if (ar_fire) begin
                M_AXI_ARREADY = 0; ar_fire = 0; ar_cnt = dly(ar_min, ar_max);
            end else if (M_AXI_ARVALID) begin
                if (ar_cnt == 0) begin
                    M_AXI_ARREADY = 1; ar_fire = 1;
                    rlog_a.push_back(8'(M_AXI_ARADDR));
                    chk("arprot", M_AXI_ARPROT, 3'b000);
                    r_pend = 1; r_cnt = dly(r_min, r_max);
                    r_data = rmem[M_AXI_ARADDR[3:2]];
                    r_resp = (8'(M_AXI_ARADDR) == err_addr) ? 2'b11 : 2'b00;
                end else ar_cnt--;
            end
            aw_hold = M_AXI_AWVALID && !aw_fire; aw_hold_a = M_AXI_AWADDR;
            w_hold  = M_AXI_WVALID && !w_fire;   w_hold_d  = M_AXI_WDATA;
            ar_hold = M_AXI_ARVALID && !ar_fire; ar_hold_a = M_AXI_ARADDR;
        end
    end

    // job-level model: key cache state as seen between jobs
    bit           m_cvld = 0;
    logic [127:0] m_ckey = '0;

    task automatic run_job(input string name, input logic [127:0] key,
                           input logic [127:0] cipher, input logic [127:0] rd,
                           input logic [7:0] eaddr, input int hold);
        logic [7:0]   ea [8];
        logic [31:0]  ed [8];
        logic [127:0] p;
        int n;
        bit skip, eerr, ok;
        skip = CACHE && m_cvld && (key == m_ckey);
        n = 0;
        for (int i = (skip ? 4 : 0); i < 8; i++) begin
            ea[n] = (i < 4) ? 8'(16 + 4 * i) : 8'(4 * (i - 4));
            ed[n] = (i < 4) ? key[32 * (3 - i) +: 32] : cipher[32 * (7 - i) +: 32];
            n++;
        end
        eerr = 0;
        for (int j = 0; j < n; j++) if (ea[j] == eaddr) eerr = 1;
        for (int j = 0; j < 4; j++) if (8'(32 + 4 * j) == eaddr) eerr = 1;
        err_addr = eaddr;
        for (int j = 0; j < 4; j++) rmem[j] = rd[32 * (3 - j) +: 32];
        wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
        ar_seen = 0;

        @(negedge ACLK);
        req_key = key; req_cipher = cipher; req_valid = 1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge ACLK);
        end
        chk({name, ":req_accept"}, ok, 1'b1);
        @(negedge ACLK);
        req_valid = 0;
        if (!ok) return;
        chk({name, ":busy_ready"}, {busy, req_ready}, 2'b10);
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            if (rsp_valid) begin ok = 1; break; end
            @(negedge ACLK);
        end
        chk({name, ":rsp_arrives"}, ok, 1'b1);
        if (!ok) return;
        p = rsp_plain;
        chk({name, ":plain"}, p, rd);
        chk({name, ":err"}, rsp_err, eerr);
        for (int h = 0; h < hold; h++) begin
            @(negedge ACLK);
            chk({name, ":rsp_hold"}, {rsp_valid, req_ready, rsp_err, rsp_plain},
                {1'b1, 1'b0, eerr, p});
        end
        rsp_ready = 1;
        @(negedge ACLK);
        rsp_ready = 0;
        chk({name, ":rsp_done"}, {rsp_valid, req_ready, busy}, 3'b010);
        chk({name, ":n_writes"}, wlog_a.size(), n);
        for (int j = 0; j < n && j < wlog_a.size(); j++)
            chk({name, ":write"}, {wlog_a[j], wlog_d[j]}, {ea[j], ed[j]});
        chk({name, ":n_reads"}, rlog_a.size(), 4);
        for (int j = 0; j < 4 && j < rlog_a.size(); j++)
            chk({name, ":read_addr"}, rlog_a[j], 8'(32 + 4 * j));
        chk({name, ":wait_gap"}, {ar_seen, 32'(ar_gap)}, {1'b1, 32'(WAITC + 1)});
        if (eerr) m_cvld = 0;
        else if (!skip) begin m_cvld = 1; m_ckey = key; end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] pick_addr(input int idx);
        if (idx < 4) return 8'(16 + 4 * idx);
        if (idx < 8) return 8'(4 * (idx - 4));
        return 8'(32 + 4 * (idx - 8));
    endfunction

    initial begin
        logic [127:0] fk, k1, k;
        bit ok;
        ARESETN = 0;
        repeat (2) @(negedge ACLK);
        chk("reset_outs",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
             rsp_valid, busy, rsp_err, M_AXI_AWPROT, M_AXI_ARPROT}, '0);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_wstrb", M_AXI_WSTRB, 4'hF);
        ARESETN = 1;

        fk = 128'h000102030405060708090a0b0c0d0e0f;
        run_job("fips", fk, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 8'hFF, 0);

        aw_min = 3; aw_max = 3; w_min = 0; w_max = 0; b_min = 2; b_max = 2;
        ar_min = 0; ar_max = 0; r_min = 0; r_max = 0;
        run_job("backpressure", fk, rnd128(), rnd128(), 8'hFF, 5);

        aw_max = 2; aw_min = 0; w_max = 2; b_min = 0; b_max = 2; ar_max = 2; r_max = 2;
        k1 = rnd128();
        run_job("err_w04", k1, rnd128(), rnd128(), 8'h04, 1);
        run_job("after_err", k1, rnd128(), rnd128(), 8'hFF, 0);
        run_job("cache_hit", k1, rnd128(), rnd128(), 8'hFF, 2);
        run_job("err_r28", k1, rnd128(), rnd128(), 8'h28, 0);
        run_job("after_rerr", k1, rnd128(), rnd128(), 8'hFF, 0);

        k = k1;
        for (int it = 0; it < 20; it++) begin
            aw_max = dly(0, 4); w_max = dly(0, 4); b_max = dly(0, 4);
            ar_max = dly(0, 4); r_max = dly(0, 4);
            if ($urandom_range(0, 1) == 0) k = rnd128();
            run_job("rand", k, rnd128(), rnd128(),
                    ($urandom_range(0, 3) == 0) ? pick_addr(dly(0, 11)) : 8'hFF,
                    dly(0, 3));
        end

        r_min = 20; r_max = 20;
        @(negedge ACLK);
        req_key = k; req_cipher = rnd128(); req_valid = 1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            if (req_ready) begin ok = 1; break; end
            @(negedge ACLK);
        end
        @(negedge ACLK);
        req_valid = 0;
        chk("midrst_accept", ok, 1'b1);
        ok = 0;
        for (int t = 0; t < 3000; t++) begin
            if (M_AXI_RREADY) begin ok = 1; break; end
            @(negedge ACLK);
        end
        chk("midrst_reach_rd", ok, 1'b1);
        ARESETN = 0;
        @(negedge ACLK);
        chk("midrst_outs",
            {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, busy, req_ready,
             M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 8'b0000_1000);
        ARESETN = 1;
        m_cvld = 0;
        r_min = 0; r_max = 2;
        run_job("post_rst", k, rnd128(), rnd128(), 8'hFF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
